// File: rtl/fd_hazard_ctrl.sv
// Front-end hazard and interrupt sequencer: PC-write, F/D load/flush and D/E bubble control,
// load-use stalls, taken branches, and the two-half return-PC save before the interrupt vector.
module fd_hazard_ctrl #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              de_mem_read,
  input  logic [REG_AW-1:0] de_rd,
  input  logic [REG_AW-1:0] fd_rs1,
  input  logic [REG_AW-1:0] fd_rs2,
  input  logic              fd_use_rs1,
  input  logic              fd_use_rs2,
  input  logic [31:0]       fd_pc,
  input  logic              int_req,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              fd_write,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              int_save_valid,
  output logic [15:0]       int_save_data,
  output logic              int_ack
);

  typedef enum logic [1:0] {IDLE, SAVE_HI, SAVE_LO, VECTOR} state_e;

  state_e      state_q, state_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic        pending_q, pending_d;
  logic        load_use;

  assign load_use = de_mem_read &&
                    ((fd_use_rs1 && (fd_rs1 == de_rd)) || (fd_use_rs2 && (fd_rs2 == de_rd)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      saved_pc_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_pc_q <= saved_pc_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    saved_pc_d     = saved_pc_q;
    pending_d      = pending_q | int_req;
    pc_write       = 1'b0;
    pc_sel         = 2'b00;
    fd_write       = 1'b0;
    fd_flush       = 1'b0;
    de_flush       = 1'b0;
    int_save_valid = 1'b0;
    int_save_data  = '0;
    int_ack        = 1'b0;

    // A memory stall freezes everything except interrupt accumulation.
    if (!mem_stall) begin
      case (state_q)
        IDLE: begin
          if (branch_taken && pending_q) begin
            // The branch target becomes the return PC; the branch itself is not taken yet.
            saved_pc_d = branch_target;
            state_d    = SAVE_HI;
            fd_flush   = 1'b1;
            de_flush   = 1'b1;
          end else if (branch_taken) begin
            pc_sel   = 2'b01;
            pc_write = 1'b1;
            fd_write = 1'b1;
            fd_flush = 1'b1;
            de_flush = 1'b1;
          end else if (pending_q) begin
            saved_pc_d = fd_pc;
            state_d    = SAVE_HI;
            fd_flush   = 1'b1;
          end else if (load_use) begin
            de_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
            fd_write = 1'b1;
          end
        end
        SAVE_HI, SAVE_LO: begin
          if (branch_taken) begin
            // An older branch retires mid-save: restart the save with its target.
            saved_pc_d = branch_target;
            state_d    = SAVE_HI;
            fd_flush   = 1'b1;
            de_flush   = 1'b1;
          end else begin
            int_save_valid = 1'b1;
            int_save_data  = (state_q == SAVE_HI) ? saved_pc_q[31:16] : saved_pc_q[15:0];
            fd_flush       = 1'b1;
            state_d        = (state_q == SAVE_HI) ? SAVE_LO : VECTOR;
          end
        end
        VECTOR: begin
          pc_sel    = 2'b10;
          pc_write  = 1'b1;
          fd_write  = 1'b1;
          fd_flush  = 1'b1;
          int_ack   = 1'b1;
          pending_d = int_req;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (!rst_n) begin
      pc_write       = 1'b0;
      pc_sel         = 2'b00;
      fd_write       = 1'b0;
      fd_flush       = 1'b1;
      de_flush       = 1'b1;
      int_save_valid = 1'b0;
      int_save_data  = '0;
      int_ack        = 1'b0;
    end
  end

endmodule
